gtx_quad_reset_seq: RTL and testbench

Reset and initialization sequencer for the four-lane GTX quad (lanes X0Y12–X0Y15, quad 3 reference clock). It sits between the system clock domain and the transceiver wrapper. It drives the quad PLL reset and the shared GT TX/RX resets, waits for lock and per-lane reset-done, retries on timeout and reports link readiness. It also exposes a state code for the ChipScope control core.

---
 rtl/gtx_quad_reset_seq_if.sv | 31 +++
 rtl/gtx_quad_reset_seq.sv | 174 +++++++++++++++++
 tb/tb_gtx_quad_reset_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gtx_quad_reset_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gtx_quad_reset_seq_if : lock/reset-done status in, quad resets and status out
// Revision 1.0
// ----------------------------------------------------------------------------
interface gtx_quad_reset_seq_if #(
  parameter int LANES = 4
);
  logic             pll_lock;
  logic [LANES-1:0] tx_resetdone;
  logic [LANES-1:0] rx_resetdone;
  logic             restart;
  logic             pll_reset;
  logic             gt_tx_reset;
  logic             gt_rx_reset;
  logic             ready;
  logic             fail;
  logic [7:0]       retry_cnt;
  logic [2:0]       state;

  modport master (
    input  pll_lock, tx_resetdone, rx_resetdone, restart,
    output pll_reset, gt_tx_reset, gt_rx_reset, ready, fail, retry_cnt, state
  );

  modport slave (
    output pll_lock, tx_resetdone, rx_resetdone, restart,
    input  pll_reset, gt_tx_reset, gt_rx_reset, ready, fail, retry_cnt, state
  );
endinterface
`default_nettype wire

// File: rtl/gtx_quad_reset_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gtx_quad_reset_seq : PLL / GT reset sequencer for a four-lane GTX quad
// Revision 1.0
// ----------------------------------------------------------------------------
module gtx_quad_reset_seq #(
  parameter int LANES          = 4,
  parameter int WAIT_CYCLES    = 500,
  parameter int PLL_RST_CYCLES = 16,
  parameter int GT_RST_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRY      = 3
) (
  input  wire logic            SYSCLOCK_I,
  input  wire logic            RESET_I,
  gtx_quad_reset_seq_if.master seq
);

  localparam int C_MAX_A = (WAIT_CYCLES > PLL_RST_CYCLES) ? WAIT_CYCLES : PLL_RST_CYCLES;
  localparam int C_MAX_B = (GT_RST_CYCLES > TIMEOUT_CYCLES) ? GT_RST_CYCLES : TIMEOUT_CYCLES;
  localparam int C_MAX   = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int CNT_W   = $clog2(C_MAX + 1);

  localparam logic [CNT_W-1:0] C_WAIT_LAST    = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_GT_RST_LAST  = CNT_W'(GT_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       C_MAX_RETRY    = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_PWRUP     = 3'd0,
    ST_PLL_RST   = 3'd1,
    ST_PLL_WAIT  = 3'd2,
    ST_GT_RST    = 3'd3,
    ST_DONE_WAIT = 3'd4,
    ST_READY     = 3'd5,
    ST_FAIL      = 3'd6
  } state_t;

  logic                 r_lock_meta;
  logic                 r_lock_sync;
  logic [2*LANES-1:0]   r_done_meta;
  logic [2*LANES-1:0]   r_done_sync;
  logic                 w_lock_s;
  logic                 w_done_s;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_in_reset;
  logic                 w_timeout;
  logic                 w_enter;
  logic                 w_enter_ready;
  logic [7:0]           r_retry;
  logic [7:0]           w_retry_inc;

  logic                 r_pll_reset;
  logic                 r_gt_reset;
  logic                 r_ready;
  logic                 r_fail;

  always_ff @(posedge SYSCLOCK_I) begin
    if (RESET_I) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
      r_done_meta <= '0;
      r_done_sync <= '0;
    end else begin
      r_lock_meta <= seq.pll_lock;
      r_lock_sync <= r_lock_meta;
      r_done_meta <= {seq.tx_resetdone, seq.rx_resetdone};
      r_done_sync <= r_done_meta;
    end
  end

  assign w_lock_s    = r_lock_sync;
  assign w_done_s    = &r_done_sync;
  assign w_retry_inc = r_retry + 8'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      ST_PWRUP: begin
        if (r_cnt == C_WAIT_LAST) w_state_nxt = ST_PLL_RST;
      end
      ST_PLL_RST: begin
        if (r_cnt == C_PLL_RST_LAST) w_state_nxt = ST_PLL_WAIT;
      end
      ST_PLL_WAIT: begin
        if (w_lock_s)                     w_state_nxt = ST_GT_RST;
        else if (r_cnt == C_TIMEOUT_LAST) w_timeout   = 1'b1;
      end
      ST_GT_RST: begin
        if (!w_lock_s)                   w_state_nxt = ST_PLL_RST;
        else if (r_cnt == C_GT_RST_LAST) w_state_nxt = ST_DONE_WAIT;
      end
      ST_DONE_WAIT: begin
        if (!w_lock_s)                    w_state_nxt = ST_PLL_RST;
        else if (w_done_s)                w_state_nxt = ST_READY;
        else if (r_cnt == C_TIMEOUT_LAST) w_timeout   = 1'b1;
      end
      ST_READY: begin
        if (!w_lock_s)      w_state_nxt = ST_PLL_RST;
        else if (!w_done_s) w_state_nxt = ST_GT_RST;
      end
      ST_FAIL: begin
        w_state_nxt = ST_FAIL;
      end
      default: begin
        w_state_nxt = ST_PWRUP;
      end
    endcase

    if (w_timeout) begin
      w_state_nxt = (w_retry_inc == C_MAX_RETRY) ? ST_FAIL : ST_PLL_RST;
    end
    if (seq.restart) begin
      w_state_nxt = ST_PLL_RST;
      w_timeout   = 1'b0;
    end
  end

  // Leaving reset counts as entering PWRUP, so PWRUP spans the first WAIT_CYCLES free-running cycles.
  assign w_enter       = r_in_reset || seq.restart || (w_state_nxt != r_state);
  assign w_enter_ready = (w_state_nxt == ST_READY) && (r_state != ST_READY);

  always_ff @(posedge SYSCLOCK_I) begin
    if (RESET_I) begin
      r_state    <= ST_PWRUP;
      r_cnt      <= '0;
      r_in_reset <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_enter ? '0 : r_cnt + CNT_W'(1);
      r_in_reset <= 1'b0;
    end
  end

  always_ff @(posedge SYSCLOCK_I) begin
    if (RESET_I) begin
      r_retry <= '0;
    end else if (seq.restart || w_enter_ready) begin
      r_retry <= '0;
    end else if (w_timeout && (r_retry != C_MAX_RETRY)) begin
      r_retry <= w_retry_inc;
    end
  end

  always_ff @(posedge SYSCLOCK_I) begin
    if (RESET_I) begin
      r_pll_reset <= 1'b1;
      r_gt_reset  <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_pll_reset <= (w_state_nxt == ST_PWRUP) || (w_state_nxt == ST_PLL_RST);
      r_gt_reset  <= (w_state_nxt == ST_PWRUP) || (w_state_nxt == ST_PLL_RST) ||
                     (w_state_nxt == ST_PLL_WAIT) || (w_state_nxt == ST_GT_RST);
      r_ready     <= (w_state_nxt == ST_READY);
      r_fail      <= (w_state_nxt == ST_FAIL);
    end
  end

  assign seq.pll_reset   = r_pll_reset;
  assign seq.gt_tx_reset = r_gt_reset;
  assign seq.gt_rx_reset = r_gt_reset;
  assign seq.ready       = r_ready;
  assign seq.fail        = r_fail;
  assign seq.retry_cnt   = r_retry;
  assign seq.state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_gtx_quad_reset_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gtx_quad_reset_seq : directed bring-up scenarios plus random lock/done traffic
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_gtx_quad_reset_seq;

  localparam int LANES     = 4;
  localparam int WAIT_C    = 8;
  localparam int PLLRST_C  = 4;
  localparam int GTRST_C   = 4;
  localparam int TIMEOUT_C = 32;
  localparam int MAXRTY_C  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  gtx_quad_reset_seq_if #(.LANES(LANES)) bus ();

  gtx_quad_reset_seq #(
    .LANES(LANES), .WAIT_CYCLES(WAIT_C), .PLL_RST_CYCLES(PLLRST_C),
    .GT_RST_CYCLES(GTRST_C), .TIMEOUT_CYCLES(TIMEOUT_C), .MAX_RETRY(MAXRTY_C)
  ) dut (
    .SYSCLOCK_I(clk),
    .RESET_I   (rst),
    .seq       (bus)
  );

  always #5 clk = ~clk;

  // Reference model: phase entry is time-stamped; a phase of length N ends N edges after entry.
  int m_t = 0, m_entry = 1, m_phase = 0, m_retry = 0;
  bit m_l1 = 0, m_l2 = 0, m_d1 = 0, m_d2 = 0;

  task automatic model_edge();
    bit ls, ds, to, dn_now;
    int np, spent;
    ls     = m_l2;
    ds     = m_d2;
    dn_now = (&bus.tx_resetdone) && (&bus.rx_resetdone);
    if (rst) begin
      m_phase = 0; m_retry = 0; m_entry = m_t + 1;
      m_l1 = 0; m_l2 = 0; m_d1 = 0; m_d2 = 0;
    end else begin
      spent = m_t - m_entry;
      np    = m_phase;
      to    = 0;
      if (bus.restart) np = 1;
      else case (m_phase)
        0: if (spent == WAIT_C) np = 1;
        1: if (spent == PLLRST_C) np = 2;
        2: if (ls) np = 3; else if (spent == TIMEOUT_C) to = 1;
        3: if (!ls) np = 1; else if (spent == GTRST_C) np = 4;
        4: if (!ls) np = 1; else if (ds) np = 5; else if (spent == TIMEOUT_C) to = 1;
        5: if (!ls) np = 1; else if (!ds) np = 3;
        default: np = m_phase;
      endcase
      if (to) begin
        m_retry = (m_retry < MAXRTY_C) ? m_retry + 1 : m_retry;
        np = (m_retry == MAXRTY_C) ? 6 : 1;
      end
      if (bus.restart || (np == 5 && m_phase != 5)) m_retry = 0;
      if (bus.restart || np != m_phase) m_entry = m_t;
      m_phase = np;
      m_l2 = m_l1; m_l1 = bus.pll_lock;
      m_d2 = m_d1; m_d1 = dn_now;
    end
    m_t++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_model();
    chk("model_state",     32'(bus.state),   32'(m_phase));
    chk("model_pll_reset", 32'(bus.pll_reset), 32'(m_phase <= 1));
    chk("model_gttx",      32'(bus.gt_tx_reset), 32'(m_phase <= 3));
    chk("model_gtrx",      32'(bus.gt_rx_reset), 32'(m_phase <= 3));
    chk("model_ready",     32'(bus.ready),   32'(m_phase == 5));
    chk("model_fail",      32'(bus.fail),    32'(m_phase == 6));
    chk("model_retry",     32'(bus.retry_cnt), 32'(m_retry));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_model();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_pll_reset", 32'(bus.pll_reset), 1);
    chk("rst_gt_reset", 32'(bus.gt_tx_reset & bus.gt_rx_reset), 1);
    chk("rst_ready_fail", 32'({bus.ready, bus.fail}), 0);
    chk("rst_retry", 32'(bus.retry_cnt), 0);
    rst = 1'b0;
    cyc = -1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
    int n = 0;
    while (bus.state !== target && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.state), 32'(target));
  endtask

  function automatic int nominal_state(input int c);
    if (c < 8)  return 0;
    if (c < 12) return 1;
    if (c < 17) return 2;
    if (c < 21) return 3;
    if (c < 28) return 4;
    return 5;
  endfunction

  task automatic stuck_lane_first_timeout();
    bus.pll_lock = 1'b1; bus.tx_resetdone = '1; bus.rx_resetdone = 4'b1011; bus.restart = 1'b0;
    reset_dut();
    while (cyc < 49) begin
      tick();
      if (cyc == 48) chk("stuck_done_wait", 32'(bus.state), 4);
    end
    chk("stuck_timeout_state", 32'(bus.state), 1);
    chk("stuck_retry1", 32'(bus.retry_cnt), 1);
    chk("stuck_pll_reset", 32'(bus.pll_reset), 1);
  endtask

  initial begin
    bus.pll_lock = 1'b0; bus.tx_resetdone = '0; bus.rx_resetdone = '0; bus.restart = 1'b0;

    // Nominal bring-up
    reset_dut();
    while (cyc < 30) begin
      tick();
      chk("t1_state", 32'(bus.state), 32'(nominal_state(cyc)));
      chk("t1_pll_reset", 32'(bus.pll_reset), 32'(cyc <= 11));
      chk("t1_gt_reset", 32'(bus.gt_tx_reset), 32'(cyc < 21));
      chk("t1_ready", 32'(bus.ready), 32'(cyc >= 28));
      if (cyc == 14) bus.pll_lock = 1'b1;
      if (cyc == 25) begin bus.tx_resetdone = '1; bus.rx_resetdone = '1; end
    end

    // Lock loss in READY
    bus.pll_lock = 1'b0;
    tick(); tick();
    chk("t4_ready_held", 32'(bus.ready), 1);
    tick();
    chk("t4_ready_drop", 32'(bus.ready), 0);
    chk("t4_state_pllrst", 32'(bus.state), 1);
    chk("t4_pll_reset", 32'(bus.pll_reset), 1);
    chk("t4_retry_same", 32'(bus.retry_cnt), 0);
    bus.pll_lock = 1'b1;
    wait_state("t4_reready", 3'd5, 40);

    // Lane reset-done loss in READY
    bus.tx_resetdone[1] = 1'b0;
    tick(); tick();
    chk("t4b_still_ready", 32'(bus.state), 5);
    tick();
    chk("t4b_state_gtrst", 32'(bus.state), 3);
    chk("t4b_gt_reset", 32'(bus.gt_tx_reset), 1);
    bus.tx_resetdone[1] = 1'b1;
    wait_state("t4b_reready", 3'd5, 20);

    // Lock never asserts -> FAIL, then RESTART
    bus.pll_lock = 1'b0; bus.tx_resetdone = '0; bus.rx_resetdone = '0;
    reset_dut();
    while (cyc < 85) begin
      tick();
      chk("t2_pll_reset", 32'(bus.pll_reset), 32'((cyc < 12) || (cyc >= 44 && cyc < 48)));
      chk("t2_gt_reset", 32'(bus.gt_rx_reset), 32'(cyc < 80));
      if (cyc == 43) chk("t2_state_wait1", 32'(bus.state), 2);
      if (cyc == 44) chk("t2_retry1", 32'(bus.retry_cnt), 1);
      if (cyc == 48) chk("t2_state_wait2", 32'(bus.state), 2);
      if (cyc == 80) begin
        chk("t2_fail", 32'(bus.fail), 1);
        chk("t2_retry2", 32'(bus.retry_cnt), 2);
        chk("t2_state_fail", 32'(bus.state), 6);
      end
    end
    chk("t2_fail_sticky", 32'(bus.fail), 1);
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    chk("t5_fail_clear", 32'(bus.fail), 0);
    chk("t5_retry_clear", 32'(bus.retry_cnt), 0);
    chk("t5_pll_reset", 32'(bus.pll_reset), 1);
    chk("t5_state", 32'(bus.state), 1);

    // One lane stuck, released on the second attempt
    stuck_lane_first_timeout();
    wait_state("t3_second_done_wait", 3'd4, 20);
    bus.rx_resetdone[2] = 1'b1;
    wait_state("t3_ready", 3'd5, 10);
    chk("t3_retry_clear", 32'(bus.retry_cnt), 0);
    chk("t3_ready_out", 32'(bus.ready), 1);

    // Reset mid-DONE_WAIT with a non-zero retry count
    stuck_lane_first_timeout();
    wait_state("t5b_done_wait", 3'd4, 20);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("t5b_state", 32'(bus.state), 0);
    chk("t5b_retry", 32'(bus.retry_cnt), 0);
    chk("t5b_resets", 32'({bus.pll_reset, bus.gt_tx_reset, bus.gt_rx_reset}), 32'h7);
    chk("t5b_ready_fail", 32'({bus.ready, bus.fail}), 0);
    rst = 1'b0;

    // Lock lands exactly on the PLL_WAIT timeout cycle
    bus.pll_lock = 1'b0; bus.tx_resetdone = '0; bus.rx_resetdone = '0;
    reset_dut();
    while (cyc < 41) tick();
    bus.pll_lock = 1'b1;
    tick(); tick();
    chk("t6_still_wait", 32'(bus.state), 2);
    tick();
    chk("t6_gt_rst", 32'(bus.state), 3);
    chk("t6_retry", 32'(bus.retry_cnt), 0);

    // Random lock/done/restart/reset traffic against the model
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      int r;
      tick();
      if ($urandom_range(0, 59) == 0) bus.pll_lock = ~bus.pll_lock;
      r = $urandom_range(0, 39);
      if (r == 0)      begin bus.tx_resetdone = '1; bus.rx_resetdone = '1; end
      else if (r == 1) bus.tx_resetdone[$urandom_range(0, 3)] = 1'b0;
      else if (r == 2) bus.rx_resetdone[$urandom_range(0, 3)] = 1'b0;
      bus.restart = ($urandom_range(0, 299) == 0);
      rst         = ($urandom_range(0, 799) == 0);
    end
    bus.restart = 1'b0;
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
